// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (TX and RX paths).
// Holds the TX FSM state encoding and the fixed line-level / parity-type constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-in / serial-out bundle between the upstream TX source and uart_tx.
// Signals:
//   P_DATA, DATA_VALID, PAR_EN, PAR_TYP : byte and frame config, driven by the source
//   TX_OUT, busy                        : serial line and frame-in-progress flag, driven by uart_tx
// Modports: master = upstream source, slave = uart_tx.
interface uart_tx_if #(
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      output TX_OUT, busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data shift register and bit counter for uart_tx.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data into the shift register
//   load_data  : byte to serialise
//   shift_en   : shift right by one (LSB first out)
//   cnt_en     : advance the data-bit counter
//   ser_bit    : current shift register LSB
//   ser_done   : high while the counter is on the last data bit
module uart_tx_serializer #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift_en,
   input  logic                  cnt_en,
   output logic                  ser_bit,
   output logic                  ser_done
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      cnt_q;

   // Shift register and wrapping bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (load) begin
            shift_q <= load_data;
         end else if (shift_en) begin
            shift_q <= shift_q >> 1;
         end
         if (cnt_en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         end
      end
   end

   assign ser_bit  = shift_q[0];
   assign ser_done = cnt_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one clk per bit period.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Ports:
//   clk, rst : UART TX clock, synchronous active-high reset
//   bus      : uart_tx_if slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP in; TX_OUT, busy out)
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   tx_state_e state_q, state_d;
   logic      tx_q, busy_q, par_q, par_en_q;
   logic      tx_d, busy_d;
   logic      load, shift_en, cnt_en;
   logic      ser_bit, ser_done;

   // The line is registered from the next state, so the shift register is
   // pre-shifted once in START: in START/DATA its LSB is the bit for the next cycle.
   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (bus.P_DATA),
      .shift_en  (shift_en),
      .cnt_en    (cnt_en),
      .ser_bit   (ser_bit),
      .ser_done  (ser_done)
   );

   // State, output and frame-config registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tx_q     <= IDLE_LEVEL;
         busy_q   <= 1'b0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         if (load) begin
            par_en_q <= bus.PAR_EN;
            par_q    <= (^bus.P_DATA) ^ (bus.PAR_TYP == PAR_ODD);
         end
      end
   end

   // Next state, serializer controls and next line level.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      shift_en = 1'b0;
      cnt_en   = 1'b0;
      tx_d     = IDLE_LEVEL;
      busy_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.DATA_VALID) begin
               load    = 1'b1;
               state_d = START;
            end
         end
         START: begin
            shift_en = 1'b1;
            state_d  = DATA;
         end
         DATA: begin
            shift_en = 1'b1;
            cnt_en   = 1'b1;
            if (ser_done) begin
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            state_d = STOP;
         end
         STOP: begin
            // Back-to-back acceptance: next frame starts with no idle bit.
            if (bus.DATA_VALID) begin
               load    = 1'b1;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   tx_d = START_BIT;
         DATA:    tx_d = ser_bit;
         PARITY:  tx_d = par_q;
         STOP:    tx_d = STOP_BIT;
         default: tx_d = IDLE_LEVEL;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.TX_OUT = tx_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
module tb_uart_tx;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   uart_tx_if #(.DATA_WIDTH(8)) u_if ();

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle DATA_VALID strobe; returns in the start-bit cycle.
   task automatic strobe(input logic [7:0] d, input logic pen, input logic ptyp);
      u_if.P_DATA     = d;
      u_if.PAR_EN     = pen;
      u_if.PAR_TYP    = ptyp;
      u_if.DATA_VALID = 1'b1;
      tick();
      u_if.DATA_VALID = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      u_if.DATA_VALID = 1'b0;
      u_if.P_DATA     = 8'h00;
      u_if.PAR_EN     = 1'b0;
      u_if.PAR_TYP    = 1'b0;
      repeat (3) tick();
      checks++;
      if (u_if.TX_OUT !== 1'b1) begin
         errors++;
         $display("FAIL reset TX_OUT: got %b want 1", u_if.TX_OUT);
      end
      checks++;
      if (u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset busy: got %b want 0", u_if.busy);
      end
      rst = 1'b0;
      tick();
   endtask

   // 0xA5, no parity: 0, 1,0,1,0,0,1,0,1, 1 then idle.
   task automatic test_no_parity();
      logic [9:0] exp;
      exp = {1'b1, 8'hA5, 1'b0};
      strobe(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (u_if.TX_OUT !== exp[i] || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL nopar_a5 bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                     i, u_if.TX_OUT, u_if.busy, exp[i]);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL nopar_a5 idle %0d: TX_OUT=%b busy=%b want 1/0",
                     i, u_if.TX_OUT, u_if.busy);
         end
         tick();
      end
   endtask

   // 0xA5 even (parity 0), 0xA5 odd (parity 1, config changed mid-frame), 0x07 even (parity 1).
   task automatic test_parity();
      logic [10:0] exp [3];
      logic [7:0]  dat [3];
      logic        typ [3];
      exp[0] = {1'b1, 1'b0, 8'hA5, 1'b0}; dat[0] = 8'hA5; typ[0] = 1'b0;
      exp[1] = {1'b1, 1'b1, 8'hA5, 1'b0}; dat[1] = 8'hA5; typ[1] = 1'b1;
      exp[2] = {1'b1, 1'b1, 8'h07, 1'b0}; dat[2] = 8'h07; typ[2] = 1'b0;
      for (int t = 0; t < 3; t++) begin
         strobe(dat[t], 1'b1, typ[t]);
         // Latched config must win over later input changes.
         u_if.PAR_EN  = 1'b0;
         u_if.PAR_TYP = ~typ[t];
         for (int i = 0; i < 11; i++) begin
            checks++;
            if (u_if.TX_OUT !== exp[t][i] || u_if.busy !== 1'b1) begin
               errors++;
               $display("FAIL parity_%0d bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                        t, i, u_if.TX_OUT, u_if.busy, exp[t][i]);
            end
            tick();
         end
         checks++;
         if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL parity_%0d end: TX_OUT=%b busy=%b want 1/0",
                     t, u_if.TX_OUT, u_if.busy);
         end
         tick();
      end
   endtask

   // 0x00 then 0xFF strobed in the 0x00 stop cycle.
   task automatic test_back_to_back();
      logic [9:0] exp0, exp1;
      exp0 = {1'b1, 8'h00, 1'b0};
      exp1 = {1'b1, 8'hFF, 1'b0};
      strobe(8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (u_if.TX_OUT !== exp0[i] || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_00 bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                     i, u_if.TX_OUT, u_if.busy, exp0[i]);
         end
         if (i == 9) begin
            strobe(8'hFF, 1'b0, 1'b0);
         end else begin
            tick();
         end
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (u_if.TX_OUT !== exp1[i] || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ff bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                     i, u_if.TX_OUT, u_if.busy, exp1[i]);
         end
         tick();
      end
      checks++;
      if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b end: TX_OUT=%b busy=%b want 1/0", u_if.TX_OUT, u_if.busy);
      end
      tick();
   endtask

   // 0x3C with a 0x81 strobe during data bit 3; the strobe must be dropped.
   task automatic test_ignored_strobe();
      logic [9:0] exp;
      exp = {1'b1, 8'h3C, 1'b0};
      strobe(8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (u_if.TX_OUT !== exp[i] || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_3c bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                     i, u_if.TX_OUT, u_if.busy, exp[i]);
         end
         if (i == 4) begin
            strobe(8'h81, 1'b1, 1'b1);
         end else begin
            tick();
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore idle %0d: TX_OUT=%b busy=%b want 1/0",
                     i, u_if.TX_OUT, u_if.busy);
         end
         tick();
      end
   endtask

   // Reset during data bit 5 of 0x55, then a clean 0x12 frame.
   task automatic test_reset_mid_frame();
      logic [9:0] exp0, exp1;
      exp0 = {1'b1, 8'h55, 1'b0};
      exp1 = {1'b1, 8'h12, 1'b0};
      strobe(8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (u_if.TX_OUT !== exp0[i] || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_55 bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                     i, u_if.TX_OUT, u_if.busy, exp0[i]);
         end
         if (i == 6) rst = 1'b1;
         tick();
      end
      rst = 1'b0;
      checks++;
      if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid after: TX_OUT=%b busy=%b want 1/0", u_if.TX_OUT, u_if.busy);
      end
      tick();
      checks++;
      if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid idle: TX_OUT=%b busy=%b want 1/0", u_if.TX_OUT, u_if.busy);
      end
      strobe(8'h12, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (u_if.TX_OUT !== exp1[i] || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_12 bit %0d: TX_OUT=%b busy=%b want TX_OUT=%b busy=1",
                     i, u_if.TX_OUT, u_if.busy, exp1[i]);
         end
         tick();
      end
      checks++;
      if (u_if.TX_OUT !== 1'b1 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_12 end: TX_OUT=%b busy=%b want 1/0", u_if.TX_OUT, u_if.busy);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_no_parity();
      test_parity();
      test_back_to_back();
      test_ignored_strobe();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
